// File: rtl/decode_ctrl_if.sv
// Decode-stage bus: fetched instruction in, ID/EX register contents out.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef EXE_CMD_LEN
`define EXE_CMD_LEN 4
`endif

interface decode_ctrl_if;
  logic [`WORD_LEN-1:0]    instr_in;
  logic                    instr_valid;
  logic [`WORD_LEN-1:0]    pc_in;
  logic                    flush;
  logic [`EXE_CMD_LEN-1:0] exe_cmd;
  logic                    mem_r_en;
  logic                    mem_w_en;
  logic                    wb_en;
  logic                    is_imm;
  logic [1:0]              br_type;
  logic [4:0]              dest;
  logic [4:0]              src1;
  logic [4:0]              src2;
  logic [`WORD_LEN-1:0]    imm_sext;
  logic [`WORD_LEN-1:0]    pc_out;
  logic                    valid_out;
  logic                    illegal;
  logic                    hazard_stall;

  // Upstream (fetch side / consumer of ID/EX)
  modport master (
    output instr_in, instr_valid, pc_in, flush,
    input  exe_cmd, mem_r_en, mem_w_en, wb_en, is_imm, br_type,
           dest, src1, src2, imm_sext, pc_out, valid_out, illegal, hazard_stall
  );

  // Decode stage
  modport slave (
    input  instr_in, instr_valid, pc_in, flush,
    output exe_cmd, mem_r_en, mem_w_en, wb_en, is_imm, br_type,
           dest, src1, src2, imm_sext, pc_out, valid_out, illegal, hazard_stall
  );
endinterface

// File: rtl/decode_ctrl.sv
// Instruction decode with ID/EX register and single-cycle load-use interlock.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef EXE_CMD_LEN
`define EXE_CMD_LEN 4
`endif
`ifndef EXE_ADD
`define EXE_ADD 4'b0000
`endif
`ifndef EXE_SUB
`define EXE_SUB 4'b0010
`endif
`ifndef EXE_AND
`define EXE_AND 4'b0100
`endif
`ifndef EXE_OR
`define EXE_OR 4'b0101
`endif
`ifndef EXE_NO_OPERATION
`define EXE_NO_OPERATION 4'b1111
`endif

module decode_ctrl (
  input  logic          clk,
  input  logic          rst,
  decode_ctrl_if.slave  bus
);
  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  typedef struct packed {
    logic                    valid;
    logic [`EXE_CMD_LEN-1:0] exe_cmd;
    logic                    mem_r_en;
    logic                    mem_w_en;
    logic                    wb_en;
    logic                    is_imm;
    logic [1:0]              br_type;
    logic [4:0]              dest;
    logic [4:0]              src1;
    logic [4:0]              src2;
    logic [`WORD_LEN-1:0]    imm_sext;
    logic [`WORD_LEN-1:0]    pc;
  } idex_t;

  idex_t                idex_q, dec, bubble, idex_d;
  logic                 ld_pending;
  logic [4:0]           ld_dest;
  logic                 illegal_q;
  logic [5:0]           opcode;
  logic [4:0]           f_rd, f_rs, f_rt;
  logic [`WORD_LEN-1:0] imm;
  logic                 legal, rd1, rd2, hazard, live, issue, ld_set;

  assign opcode = bus.instr_in[31:26];
  assign f_rd   = bus.instr_in[25:21];
  assign f_rs   = bus.instr_in[20:16];
  assign f_rt   = bus.instr_in[15:11];
  assign imm    = {{16{bus.instr_in[15]}}, bus.instr_in[15:0]};

  // Opcode table: decoded ID/EX contents plus which register fields are read
  always_comb begin
    bubble         = '0;
    bubble.exe_cmd = `EXE_NO_OPERATION;
    dec            = bubble;
    legal          = 1'b1;
    rd1            = 1'b0;
    rd2            = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        dec.valid = 1'b1;
        dec.wb_en = 1'b1;
        dec.dest  = f_rd;
        dec.src1  = f_rs;
        dec.src2  = f_rt;
        rd1       = 1'b1;
        rd2       = 1'b1;
        case (opcode)
          OP_SUB:  dec.exe_cmd = `EXE_SUB;
          OP_AND:  dec.exe_cmd = `EXE_AND;
          OP_OR:   dec.exe_cmd = `EXE_OR;
          default: dec.exe_cmd = `EXE_ADD;
        endcase
      end
      OP_ADDI, OP_LD: begin
        dec.valid    = 1'b1;
        dec.exe_cmd  = `EXE_ADD;
        dec.is_imm   = 1'b1;
        dec.wb_en    = 1'b1;
        dec.mem_r_en = (opcode == OP_LD);
        dec.dest     = f_rd;
        dec.src1     = f_rs;
        dec.imm_sext = imm;
        rd1          = 1'b1;
      end
      OP_ST: begin
        dec.valid    = 1'b1;
        dec.exe_cmd  = `EXE_ADD;
        dec.is_imm   = 1'b1;
        dec.mem_w_en = 1'b1;
        dec.src1     = f_rs;
        dec.src2     = f_rd;
        dec.imm_sext = imm;
        rd1          = 1'b1;
        rd2          = 1'b1;
      end
      OP_BEZ, OP_BNE: begin
        dec.valid    = 1'b1;
        dec.br_type  = (opcode == OP_BEZ) ? 2'd1 : 2'd2;
        dec.src1     = f_rs;
        dec.src2     = f_rd;
        dec.imm_sext = imm;
        rd1          = 1'b1;
        rd2          = (opcode == OP_BNE);
      end
      OP_JMP: begin
        dec.valid    = 1'b1;
        dec.br_type  = 2'd3;
        dec.is_imm   = 1'b1;
        dec.imm_sext = imm;
      end
      default: legal = 1'b0;
    endcase
    // r0 is hardwired; writing it is meaningless
    if (dec.dest == 5'd0) dec.wb_en = 1'b0;
    if (dec.valid) dec.pc = bus.pc_in;
  end

  // Interlock and issue qualification; flush and reset override everything
  always_comb begin
    live   = !rst && bus.instr_valid && !bus.flush;
    hazard = live && ld_pending && (ld_dest != 5'd0) &&
             ((rd1 && dec.src1 == ld_dest) || (rd2 && dec.src2 == ld_dest));
    issue  = live && legal && !hazard && dec.valid;
    ld_set = issue && (opcode == OP_LD) && (dec.dest != 5'd0);
    idex_d = issue ? dec : bubble;
  end

  // ID/EX register and load-tracking state
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q     <= bubble;
      illegal_q  <= 1'b0;
      ld_pending <= 1'b0;
      ld_dest    <= 5'd0;
    end else begin
      idex_q     <= idex_d;
      illegal_q  <= live && !legal;
      ld_pending <= ld_set;
      ld_dest    <= ld_set ? dec.dest : 5'd0;
    end
  end

  assign bus.valid_out    = idex_q.valid;
  assign bus.exe_cmd      = idex_q.exe_cmd;
  assign bus.mem_r_en     = idex_q.mem_r_en;
  assign bus.mem_w_en     = idex_q.mem_w_en;
  assign bus.wb_en        = idex_q.wb_en;
  assign bus.is_imm       = idex_q.is_imm;
  assign bus.br_type      = idex_q.br_type;
  assign bus.dest         = idex_q.dest;
  assign bus.src1         = idex_q.src1;
  assign bus.src2         = idex_q.src2;
  assign bus.imm_sext     = idex_q.imm_sext;
  assign bus.pc_out       = idex_q.pc;
  assign bus.illegal      = illegal_q;
  assign bus.hazard_stall = hazard;
endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl: reset, load-use interlock, flush, illegal, field decode.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef EXE_CMD_LEN
`define EXE_CMD_LEN 4
`endif
`ifndef EXE_ADD
`define EXE_ADD 4'b0000
`endif
`ifndef EXE_SUB
`define EXE_SUB 4'b0010
`endif
`ifndef EXE_AND
`define EXE_AND 4'b0100
`endif
`ifndef EXE_OR
`define EXE_OR 4'b0101
`endif
`ifndef EXE_NO_OPERATION
`define EXE_NO_OPERATION 4'b1111
`endif

module tb_decode_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] pc = 32'h100;

  always #5 clk = ~clk;

  decode_ctrl_if bus ();
  decode_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rt(input int op, input int rd, input int rs, input int r2);
    rt = {op[5:0], rd[4:0], rs[4:0], r2[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] it(input int op, input int rd, input int rs, input int im);
    it = {op[5:0], rd[4:0], rs[4:0], im[15:0]};
  endfunction

  // Present an instruction; pc advances so pc_out can be tracked
  task automatic drive(input logic [31:0] ins, input logic v, input logic fl);
    bus.instr_in    = ins;
    bus.instr_valid = v;
    bus.flush       = fl;
    pc              = pc + 32'd4;
    bus.pc_in       = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, 32'(bus.valid_out), 32'd0);
    chk({tag, ".exe"}, 32'(bus.exe_cmd), 32'(`EXE_NO_OPERATION));
    chk({tag, ".en"}, {29'd0, bus.mem_r_en, bus.mem_w_en, bus.wb_en}, 32'd0);
    chk({tag, ".regs"}, {17'd0, bus.dest, bus.src1, bus.src2}, 32'd0);
    chk({tag, ".imm"}, bus.imm_sext, 32'd0);
    chk({tag, ".pc"}, bus.pc_out, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(rt(1, 3, 1, 2), 1'b1, 1'b0);
    chk("rst.stall", 32'(bus.hazard_stall), 32'd0);
    tick();
    tick();
    chk_bubble("rst");
    chk("rst.illegal", 32'(bus.illegal), 32'd0);

    // ADD r3,r1,r2 right after reset release
    rst = 1'b0;
    #1;
    chk("add.stall", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk("add.valid", 32'(bus.valid_out), 32'd1);
    chk("add.exe", 32'(bus.exe_cmd), 32'(`EXE_ADD));
    chk("add.regs", {17'd0, bus.dest, bus.src1, bus.src2}, {17'd0, 5'd3, 5'd1, 5'd2});
    chk("add.wb", 32'(bus.wb_en), 32'd1);
    chk("add.pc", bus.pc_out, pc);

    // Load-use: LD r4,8(r1); ADD r5,r4,r2
    drive(it(36, 4, 1, 8), 1'b1, 1'b0);
    chk("ld.stall", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk("ld.mem_r", 32'(bus.mem_r_en), 32'd1);
    chk("ld.imm", bus.imm_sext, 32'd8);
    chk("ld.wb_dest", {26'd0, bus.wb_en, bus.dest}, {26'd0, 1'b1, 5'd4});
    drive(rt(1, 5, 4, 2), 1'b1, 1'b0);
    chk("lu.stall", 32'(bus.hazard_stall), 32'd1);
    tick();
    chk_bubble("lu.bub");
    chk("lu.stall2", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk("lu.issue", {26'd0, bus.valid_out, bus.dest}, {26'd0, 1'b1, 5'd5});
    chk("lu.src1", 32'(bus.src1), 32'd4);

    // LD r0 never creates a hazard, and its wb_en is dropped
    drive(it(36, 0, 1, 0), 1'b1, 1'b0);
    tick();
    chk("ld0.en", {30'd0, bus.mem_r_en, bus.wb_en}, 32'b10);
    drive(rt(1, 5, 0, 2), 1'b1, 1'b0);
    chk("ld0.stall", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk("ld0.issue", 32'(bus.valid_out), 32'd1);

    // LD r4 then unrelated SUB r6,r1,r2
    drive(it(36, 4, 1, 0), 1'b1, 1'b0);
    tick();
    drive(rt(3, 6, 1, 2), 1'b1, 1'b0);
    chk("sub.stall", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk("sub.exe", {27'd0, bus.valid_out, bus.exe_cmd}, {27'd0, 1'b1, 4'(`EXE_SUB)});
    chk("sub.dest", 32'(bus.dest), 32'd6);

    // Flush beats hazard and clears the pending load
    drive(it(36, 4, 1, 0), 1'b1, 1'b0);
    tick();
    drive(rt(1, 5, 4, 2), 1'b1, 1'b1);
    chk("fl.stall", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk_bubble("fl.bub");
    drive(rt(1, 5, 4, 2), 1'b1, 1'b0);
    chk("fl.next_stall", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk("fl.issue", 32'(bus.valid_out), 32'd1);

    // Illegal opcode pulses illegal for one cycle; flush and invalid suppress it
    drive({6'd63, 26'd0}, 1'b1, 1'b0);
    tick();
    chk("ill.pulse", 32'(bus.illegal), 32'd1);
    chk_bubble("ill.bub");
    drive(32'd0, 1'b1, 1'b0);
    tick();
    chk("ill.one", 32'(bus.illegal), 32'd0);
    drive({6'd63, 26'd0}, 1'b1, 1'b1);
    tick();
    chk("ill.flush", 32'(bus.illegal), 32'd0);
    drive({6'd63, 26'd0}, 1'b0, 1'b0);
    tick();
    chk("ill.inval", 32'(bus.illegal), 32'd0);

    // ADDI r2,r1,0xFFFF sign extension
    drive(it(32, 2, 1, 16'hFFFF), 1'b1, 1'b0);
    tick();
    chk("addi.imm", bus.imm_sext, 32'hFFFF_FFFF);
    chk("addi.is_imm", 32'(bus.is_imm), 32'd1);

    // AND / OR commands
    drive(rt(5, 1, 2, 3), 1'b1, 1'b0);
    tick();
    chk("and.exe", 32'(bus.exe_cmd), 32'(`EXE_AND));
    chk("and.imm", bus.imm_sext, 32'd0);
    drive(rt(6, 1, 2, 3), 1'b1, 1'b0);
    tick();
    chk("or.exe", 32'(bus.exe_cmd), 32'(`EXE_OR));

    // ST r7,4(r1)
    drive(it(37, 7, 1, 4), 1'b1, 1'b0);
    tick();
    chk("st.en", {29'd0, bus.mem_r_en, bus.mem_w_en, bus.wb_en}, 32'b010);
    chk("st.src", {22'd0, bus.src1, bus.src2}, {22'd0, 5'd1, 5'd7});
    chk("st.dest", 32'(bus.dest), 32'd0);

    // ST data register ([25:21]) is a real read for the interlock
    drive(it(36, 4, 1, 0), 1'b1, 1'b0);
    tick();
    drive(it(37, 4, 1, 0), 1'b1, 1'b0);
    chk("st.stall", 32'(bus.hazard_stall), 32'd1);
    tick();
    chk("st.bub", 32'(bus.valid_out), 32'd0);

    // BNE r1,r2 with negative offset
    drive(it(41, 2, 1, 16'hFFF0), 1'b1, 1'b0);
    tick();
    chk("bne.br", {29'd0, bus.br_type, bus.wb_en}, {29'd0, 2'd2, 1'b0});
    chk("bne.imm", bus.imm_sext, 32'hFFFF_FFF0);

    // BEZ reads only src1: LD r4 then BEZ with r4 in the unread field
    drive(it(36, 4, 1, 0), 1'b1, 1'b0);
    tick();
    drive(it(40, 4, 3, 2), 1'b1, 1'b0);
    chk("bez.stall", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk("bez.br", 32'(bus.br_type), 32'd1);

    // JMP
    drive(it(42, 0, 0, 16'h0010), 1'b1, 1'b0);
    tick();
    chk("jmp.br", {30'd0, bus.br_type}, 32'd3);
    chk("jmp.is_imm", 32'(bus.is_imm), 32'd1);

    // Reset in the middle of a pending load discards the stall
    drive(it(36, 4, 1, 0), 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    drive(rt(1, 5, 4, 2), 1'b1, 1'b0);
    chk("rmid.stall_rst", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk("rmid.bub", 32'(bus.valid_out), 32'd0);
    rst = 1'b0;
    #1;
    chk("rmid.stall", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk("rmid.issue", {26'd0, bus.valid_out, bus.dest}, {26'd0, 1'b1, 5'd5});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
